// File: rtl/issue_pkg.sv
// Shared types and RV32I opcode constants for the dual-issue fetch scheduler.
package issue_pkg;

  typedef enum logic [1:0] {
    PAIR   = 2'd0,
    BUBBLE = 2'd1,
    SPLIT  = 2'd2
  } issue_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // True when reg is a source that the instruction actually reads.
  function automatic logic src_hit(input logic [4:0] reg_idx,
                                   input logic [4:0] rs1, input logic uses_rs1,
                                   input logic [4:0] rs2, input logic uses_rs2);
    return (uses_rs1 && (rs1 == reg_idx)) || (uses_rs2 && (rs2 == reg_idx));
  endfunction

endpackage

// File: rtl/instr_regs_decode.sv
// Register-usage decode of one fetched instruction: which fields are real
// sources/destination, plus memory and jump classification.
module instr_regs_decode
  import issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_mem,
  output logic        is_jump
);

  logic [6:0] opcode;
  logic       has_rd;

  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    is_mem   = 1'b0;
    is_jump  = 1'b0;
    case (opcode)
      OP_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1; end
      OP_OPIMM:  begin uses_rs1 = 1'b1; has_rd = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; has_rd = 1'b1; is_mem = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_mem = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; has_rd = 1'b1; is_jump = 1'b1; end
      OP_JAL:    begin has_rd = 1'b1; is_jump = 1'b1; end
      OP_LUI,
      OP_AUIPC:  has_rd = 1'b1;
      default:   ;
    endcase
  end

  // x0 is never a real destination, so it can never create a dependence.
  assign writes_rd = has_rd && (rd != 5'd0);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Fetch-stage issue scheduler for the two-pipe core: dual issue, split issue,
// or load-use bubble, with execute redirects taking priority.
module dual_issue_ctrl
  import issue_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrF1,
  input  logic [31:0]       InstrF2,
  input  logic [1:0]        PCSrcE1,
  input  logic [1:0]        PCSrcE2,
  input  logic              MemReadD1,
  input  logic              MemReadD2,
  input  logic [4:0]        RdD1,
  input  logic [4:0]        RdD2,
  output logic              en1,
  output logic              en2,
  output logic              StallPipeline2,
  output logic              StallPipeline1NC,
  output logic              FlushD1,
  output logic              FlushD2,
  output logic              FlushE1,
  output logic              FlushE2,
  output logic [PERF_W-1:0] SplitCnt,
  output logic [PERF_W-1:0] BubbleCnt
);

  issue_state_t state, state_nxt;

  logic [4:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
  logic       u1_1, u2_1, wr_1, mem_1, jmp_1;
  logic       u1_2, u2_2, wr_2, mem_2, jmp_2;

  instr_regs_decode u_dec1 (
    .instr(InstrF1), .rs1(rs1_1), .rs2(rs2_1), .rd(rd_1),
    .uses_rs1(u1_1), .uses_rs2(u2_1), .writes_rd(wr_1),
    .is_mem(mem_1), .is_jump(jmp_1)
  );

  instr_regs_decode u_dec2 (
    .instr(InstrF2), .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2),
    .uses_rs1(u1_2), .uses_rs2(u2_2), .writes_rd(wr_2),
    .is_mem(mem_2), .is_jump(jmp_2)
  );

  logic raw_pair, pair_hazard, lu_1, lu_2, load_use, redirect;
  logic inc_split, inc_bubble;

  assign raw_pair    = wr_1 && src_hit(rd_1, rs1_2, u1_2, rs2_2, u2_2);
  assign pair_hazard = raw_pair || (mem_1 && mem_2) || jmp_1;

  assign lu_1 = MemReadD1 && (RdD1 != 5'd0) &&
                (src_hit(RdD1, rs1_1, u1_1, rs2_1, u2_1) ||
                 src_hit(RdD1, rs1_2, u1_2, rs2_2, u2_2));
  assign lu_2 = MemReadD2 && (RdD2 != 5'd0) &&
                (src_hit(RdD2, rs1_1, u1_1, rs2_1, u2_1) ||
                 src_hit(RdD2, rs1_2, u1_2, rs2_2, u2_2));

  // Decode holds the flushed bubble after a load-use stall, so it cannot recur.
  assign load_use = (lu_1 || lu_2) && (state != BUBBLE);
  assign redirect = (PCSrcE1 != 2'b00) || (PCSrcE2 != 2'b00);

  always_comb begin
    en1              = 1'b1;
    en2              = 1'b1;
    StallPipeline2   = 1'b0;
    StallPipeline1NC = 1'b0;
    FlushD1          = 1'b0;
    FlushD2          = 1'b0;
    FlushE1          = 1'b0;
    FlushE2          = 1'b0;
    inc_split        = 1'b0;
    inc_bubble       = 1'b0;
    state_nxt        = state;

    if (redirect) begin
      // Pipe 1 is older, so its redirect also kills pipe 2's execute-bound work.
      FlushD1   = 1'b1;
      FlushD2   = 1'b1;
      FlushE2   = (PCSrcE1 != 2'b00);
      state_nxt = PAIR;
    end else begin
      case (state)
        PAIR, BUBBLE: begin
          state_nxt = PAIR;
          if (load_use) begin
            en1        = 1'b0;
            en2        = 1'b0;
            FlushD1    = 1'b1;
            FlushD2    = 1'b1;
            inc_bubble = 1'b1;
            state_nxt  = BUBBLE;
          end else if (pair_hazard) begin
            en1              = 1'b0;
            en2              = 1'b0;
            StallPipeline2   = 1'b1;
            StallPipeline1NC = 1'b1;
            inc_split        = 1'b1;
            state_nxt        = SPLIT;
          end
        end
        SPLIT: begin
          FlushD1   = 1'b1;
          state_nxt = PAIR;
        end
        default: state_nxt = PAIR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PAIR;
      SplitCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      state <= state_nxt;
      if (inc_split && (SplitCnt != '1))
        SplitCnt <= SplitCnt + PERF_W'(1);
      if (inc_bubble && (BubbleCnt != '1))
        BubbleCnt <= BubbleCnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Table-driven, scoreboarded bench for the dual-issue scheduler.
module tb_dual_issue_ctrl;

  localparam int PERF_W = 4;
  localparam int SAT    = (1 << PERF_W) - 1;

  // Control vector bit order: {en1,en2,StallPipeline2,StallPipeline1NC,FlushD1,FlushD2,FlushE1,FlushE2}
  localparam logic [7:0] C_ISSUE = 8'b1100_0000;
  localparam logic [7:0] C_LU    = 8'b0000_1100;
  localparam logic [7:0] C_SPL   = 8'b0011_0000;
  localparam logic [7:0] C_SPL2  = 8'b1100_1000;
  localparam logic [7:0] C_RD1   = 8'b1100_1101;
  localparam logic [7:0] C_RD2   = 8'b1100_1100;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       InstrF1, InstrF2;
  logic [1:0]        PCSrcE1, PCSrcE2;
  logic              MemReadD1, MemReadD2;
  logic [4:0]        RdD1, RdD2;
  logic              en1, en2, StallPipeline2, StallPipeline1NC;
  logic              FlushD1, FlushD2, FlushE1, FlushE2;
  logic [PERF_W-1:0] SplitCnt, BubbleCnt;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .InstrF1(InstrF1), .InstrF2(InstrF2),
    .PCSrcE1(PCSrcE1), .PCSrcE2(PCSrcE2),
    .MemReadD1(MemReadD1), .MemReadD2(MemReadD2),
    .RdD1(RdD1), .RdD2(RdD2),
    .en1(en1), .en2(en2),
    .StallPipeline2(StallPipeline2), .StallPipeline1NC(StallPipeline1NC),
    .FlushD1(FlushD1), .FlushD2(FlushD2), .FlushE1(FlushE1), .FlushE2(FlushE2),
    .SplitCnt(SplitCnt), .BubbleCnt(BubbleCnt)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] i1, i2;
    logic [1:0]  pc1, pc2;
    logic        mr1, mr2;
    logic [4:0]  rd1, rd2;
    logic [7:0]  ctl;
    int          split;
    int          bubble;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] sub_i(input logic [4:0] rd, rs1, rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic vec_t mk(input string name, input logic r,
                              input logic [31:0] i1, i2,
                              input logic [1:0] pc1, pc2,
                              input logic mr1, input logic [4:0] rd1,
                              input logic mr2, input logic [4:0] rd2,
                              input logic [7:0] ctl, input int s, input int b);
    vec_t v;
    v.name = name; v.rst = r; v.i1 = i1; v.i2 = i2; v.pc1 = pc1; v.pc2 = pc2;
    v.mr1 = mr1; v.rd1 = rd1; v.mr2 = mr2; v.rd2 = rd2;
    v.ctl = ctl; v.split = s; v.bubble = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the edge; compare combinational outputs mid-cycle.
  task automatic step(input vec_t v);
    vec_t e;
    logic [7:0] ctl;
    @(posedge clk);
    #1;
    rst = v.rst; InstrF1 = v.i1; InstrF2 = v.i2; PCSrcE1 = v.pc1; PCSrcE2 = v.pc2;
    MemReadD1 = v.mr1; RdD1 = v.rd1; MemReadD2 = v.mr2; RdD2 = v.rd2;
    if (!v.rst) exp_q.push_back(v);
    @(negedge clk);
    if (!v.rst) begin
      e   = exp_q.pop_front();
      ctl = {en1, en2, StallPipeline2, StallPipeline1NC, FlushD1, FlushD2, FlushE1, FlushE2};
      check({e.name, ".ctl"},    32'(ctl),       32'(e.ctl));
      check({e.name, ".split"},  32'(SplitCnt),  e.split);
      check({e.name, ".bubble"}, 32'(BubbleCnt), e.bubble);
    end
  endtask

  initial begin
    logic [31:0] a_indep1, a_indep2, a_p1, a_raw1, a_raw2, lw_i, sw_i;
    logic [31:0] jal_i, jalr_i, lui_i, a_x0r, s_x0, a_r7, s_r7, a_zz;
    int model;

    rst = 1'b1; InstrF1 = '0; InstrF2 = '0; PCSrcE1 = '0; PCSrcE2 = '0;
    MemReadD1 = 1'b0; MemReadD2 = 1'b0; RdD1 = '0; RdD2 = '0;

    a_indep1 = add_i(5'd1, 5'd2, 5'd3);
    a_indep2 = add_i(5'd4, 5'd5, 5'd6);
    a_p1     = add_i(5'd1, 5'd2, 5'd3);
    a_raw1   = sub_i(5'd4, 5'd1, 5'd5);
    a_raw2   = add_i(5'd4, 5'd5, 5'd1);
    lw_i     = {12'd0, 5'd2, 3'b010, 5'd7, 7'b0000011};
    sw_i     = {7'd0, 5'd8, 5'd3, 3'b010, 5'd4, 7'b0100011};
    jal_i    = {20'd8, 5'd1, 7'b1101111};
    jalr_i   = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
    lui_i    = {12'd0, 5'd9, 3'b000, 5'd1, 7'b0110111};
    a_x0r    = add_i(5'd0, 5'd2, 5'd3);
    s_x0     = sub_i(5'd4, 5'd0, 5'd5);
    a_r7     = add_i(5'd1, 5'd7, 5'd3);
    s_r7     = sub_i(5'd4, 5'd1, 5'd7);
    a_zz     = add_i(5'd1, 5'd0, 5'd0);

    tbl.push_back(mk("rst0",      1, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("rst1",      1, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("reset_val", 0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("indep",     0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("raw_rs1_c0",0, a_p1, a_raw1,       0, 0, 0, 0, 0, 0, C_SPL,   0, 0));
    tbl.push_back(mk("raw_rs1_c1",0, a_p1, a_raw1,       0, 0, 0, 0, 0, 0, C_SPL2,  1, 0));
    tbl.push_back(mk("after_spl", 0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 1, 0));
    tbl.push_back(mk("x0_dep",    0, a_x0r, s_x0,        0, 0, 0, 0, 0, 0, C_ISSUE, 1, 0));
    tbl.push_back(mk("mem_c0",    0, lw_i, sw_i,         0, 0, 0, 0, 0, 0, C_SPL,   1, 0));
    tbl.push_back(mk("mem_c1",    0, lw_i, sw_i,         0, 0, 0, 0, 0, 0, C_SPL2,  2, 0));
    tbl.push_back(mk("lu_d1",     0, a_r7, a_indep2,     0, 0, 1, 7, 0, 0, C_LU,    2, 0));
    tbl.push_back(mk("lu_d1_bub", 0, a_r7, a_indep2,     0, 0, 0, 0, 0, 0, C_ISSUE, 2, 1));
    tbl.push_back(mk("lu_d2_raw", 0, a_p1, s_r7,         0, 0, 0, 0, 1, 7, C_LU,    2, 1));
    tbl.push_back(mk("bub_then_s",0, a_p1, s_r7,         0, 0, 0, 0, 0, 0, C_SPL,   2, 2));
    tbl.push_back(mk("bub_s_c1",  0, a_p1, s_r7,         0, 0, 0, 0, 0, 0, C_SPL2,  3, 2));
    tbl.push_back(mk("lu_rd_x0",  0, a_zz, a_indep2,     0, 0, 1, 0, 0, 0, C_ISSUE, 3, 2));
    tbl.push_back(mk("lu_lui",    0, lui_i, a_indep2,    0, 0, 1, 9, 0, 0, C_ISSUE, 3, 2));
    tbl.push_back(mk("pre_redir", 0, a_p1, a_raw1,       0, 0, 0, 0, 0, 0, C_SPL,   3, 2));
    tbl.push_back(mk("redir1_spl",0, a_p1, a_raw1,       1, 0, 0, 0, 0, 0, C_RD1,   4, 2));
    tbl.push_back(mk("post_redir",0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 4, 2));
    tbl.push_back(mk("redir2",    0, a_p1, a_raw1,       0, 2, 0, 0, 0, 0, C_RD2,   4, 2));
    tbl.push_back(mk("post_r2",   0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 4, 2));
    tbl.push_back(mk("redir_both",0, a_r7, a_indep2,     1, 1, 1, 7, 0, 0, C_RD1,   4, 2));
    tbl.push_back(mk("post_both", 0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 4, 2));
    tbl.push_back(mk("jal_c0",    0, jal_i, a_indep2,    0, 0, 0, 0, 0, 0, C_SPL,   4, 2));
    tbl.push_back(mk("jal_c1",    0, jal_i, a_indep2,    0, 0, 0, 0, 0, 0, C_SPL2,  5, 2));
    tbl.push_back(mk("pre_rst",   0, a_p1, a_raw1,       0, 0, 0, 0, 0, 0, C_SPL,   5, 2));
    tbl.push_back(mk("rst_mid",   1, a_p1, a_raw1,       0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("post_rst",  0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 0, 0));
    tbl.push_back(mk("jalr_c0",   0, jalr_i, a_indep2,   0, 0, 0, 0, 0, 0, C_SPL,   0, 0));
    tbl.push_back(mk("jalr_c1",   0, jalr_i, a_indep2,   0, 0, 0, 0, 0, 0, C_SPL2,  1, 0));
    tbl.push_back(mk("raw_rs2_c0",0, a_p1, a_raw2,       0, 0, 0, 0, 0, 0, C_SPL,   1, 0));
    tbl.push_back(mk("raw_rs2_c1",0, a_p1, a_raw2,       0, 0, 0, 0, 0, 0, C_SPL2,  2, 0));
    tbl.push_back(mk("idle",      0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, 2, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Drive the split counter past all-ones; it must stop at the maximum.
    model = 2;
    for (int k = 0; k < 16; k++) begin
      step(mk("sat_c0", 0, a_p1, a_raw1, 0, 0, 0, 0, 0, 0, C_SPL, model, 0));
      if (model < SAT) model++;
      step(mk("sat_c1", 0, a_p1, a_raw1, 0, 0, 0, 0, 0, 0, C_SPL2, model, 0));
    end
    step(mk("sat_final", 0, a_indep1, a_indep2, 0, 0, 0, 0, 0, 0, C_ISSUE, SAT, 0));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
